// File: rtl/dmem_copy_engine.sv
// Block copy engine for the single-port data memory.
// One read cycle and one write cycle per word, with a running 32-bit sum.
module dmem_copy_engine #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] sum,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   cnt_inc;
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    assign cnt_inc = cnt_q + {{AW{1'b0}}, 1'b1};
    // Address sums are AW bits wide, so they wrap around the memory.
    assign rd_addr = src_q + cnt_q[AW-1:0];
    assign wr_addr = dst_q + cnt_q[AW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD:   state_d = S_WR;
            S_WR:   state_d = (cnt_inc == len_q) ? S_DONE : S_RD;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch and datapath updates; start outside IDLE is dropped.
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        data_d = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = src;
                    dst_d = dst;
                    len_d = len;
                    cnt_d = '0;
                    sum_d = '0;
                end
            end
            S_RD: begin
                data_d = mem_rd;
                sum_d  = sum_q + mem_rd;
            end
            S_WR: begin
                cnt_d = cnt_inc;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        mem_we = 1'b0;
        mem_a  = '0;
        unique case (state_q)
            S_RD: begin
                busy  = 1'b1;
                mem_a = rd_addr;
            end
            S_WR: begin
                busy   = 1'b1;
                mem_we = !reset;
                mem_a  = wr_addr;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_wd = data_q;
    assign sum    = sum_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed and random checks of dmem_copy_engine against a
// word-by-word block copy model over a behavioural memory.
module tb_dmem_copy_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  src;
    logic [4:0]  dst;
    logic [5:0]  len;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        mem_we;
    logic [4:0]  mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [32];
    logic        pl_en;
    logic [4:0]  pl_a;
    logic [31:0] pl_d;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_wd;
        else if (pl_en) mem[pl_a] <= pl_d;
    end

    assign mem_rd = mem[mem_a];

    dmem_copy_engine #(.AW(5), .DW(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // gl_c: cycle in which a stray start is pulsed; rs_c: cycle in which reset is held.
    task automatic do_cmd(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l,
                          input int gl_c, input int rs_c);
        logic [31:0] ref_m [32];
        logic [31:0] esum;
        logic [31:0] w;
        logic [31:0] sum_at_done;
        int nwr, done_c, extra_done, busy_n, we_n, lim;
        nwr = int'(l);
        if (rs_c > 0) nwr = rs_c / 2 - 1;
        for (int i = 0; i < 32; i++) ref_m[i] = mem[i];
        esum = 0;
        for (int i = 0; i < nwr; i++) begin
            w = ref_m[(int'(s) + i) % 32];
            esum = esum + w;
            ref_m[(int'(d) + i) % 32] = w;
        end
        start = 1'b1;
        src = s;
        dst = d;
        len = l;
        @(posedge clk); #1;
        done_c = 0;
        extra_done = 0;
        busy_n = 0;
        we_n = 0;
        sum_at_done = 0;
        lim = 2 * int'(l) + 8;
        for (int c = 1; c <= lim; c++) begin
            start = 1'b0;
            src = 5'($urandom);
            dst = 5'($urandom);
            len = 6'($urandom);
            if (c == gl_c) begin
                start = 1'b1;
                src = s;
                dst = d + 5'd5;
                len = l;
            end
            reset = (c == rs_c);
            #1;
            if (busy) busy_n++;
            if (mem_we) we_n++;
            if (done) begin
                if (done_c == 0) begin
                    done_c = c;
                    sum_at_done = sum;
                end else begin
                    extra_done++;
                end
            end
            if (rs_c > 0 && c == rs_c) chk("we_in_reset", 32'(mem_we), 32'd0);
            if (rs_c > 0 && c == rs_c + 1) begin
                chk("busy_after_reset", 32'(busy), 32'd0);
                chk("sum_after_reset", sum, 32'd0);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        start = 1'b0;
        if (rs_c == 0) begin
            chk("done_cycle", 32'(done_c), (l == 0) ? 32'd1 : 32'(2 * int'(l) + 1));
            chk("busy_cycles", 32'(busy_n), 32'(2 * int'(l)));
            chk("sum_at_done", sum_at_done, esum);
            chk("sum_hold", sum, esum);
        end else begin
            chk("no_done_on_reset", 32'(done_c), 32'd0);
        end
        chk("extra_done", 32'(extra_done), 32'd0);
        chk("we_cycles", 32'(we_n), 32'(nwr));
        for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_m[i]);
    endtask

    initial begin
        logic [31:0] a;
        logic [4:0]  rs, rd;
        reset = 1'b1;
        start = 1'b0;
        src = '0;
        dst = '0;
        len = '0;
        pl_en = 1'b0;
        pl_a = '0;
        pl_d = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_a", 32'(mem_a), 32'd0);
        chk("rst_wd", mem_wd, 32'd0);

        for (int i = 0; i < 32; i++) poke(5'(i), $urandom);

        poke(5'd2, 32'h55);
        poke(5'd3, 32'h0);
        poke(5'd4, 32'h00020007);
        do_cmd(5'd2, 5'd20, 6'd3, 0, 0);
        chk("basic_sum", sum, 32'h0002005C);
        chk("basic_m22", mem[22], 32'h00020007);

        do_cmd(5'd7, 5'd9, 6'd0, 0, 0);
        chk("zero_sum", sum, 32'd0);

        poke(5'd30, 32'd1);
        poke(5'd31, 32'd2);
        poke(5'd0, 32'd3);
        poke(5'd1, 32'd4);
        do_cmd(5'd30, 5'd10, 6'd4, 0, 0);
        chk("wrap_sum", sum, 32'd10);
        do_cmd(5'd0, 5'd0, 6'd32, 0, 0);

        a = $urandom;
        poke(5'd0, a);
        poke(5'd1, $urandom);
        poke(5'd2, $urandom);
        poke(5'd3, $urandom);
        do_cmd(5'd0, 5'd1, 6'd3, 0, 0);
        chk("ovl_sum", sum, a * 32'd3);
        chk("ovl_m3", mem[3], a);

        do_cmd(5'd5, 5'd15, 6'd4, 2, 0);
        do_cmd(5'd8, 5'd16, 6'd2, 5, 0);

        do_cmd(5'd3, 5'd20, 6'd4, 0, 6);

        poke(5'd12, 32'hFFFFFFFF);
        poke(5'd13, 32'h00000002);
        do_cmd(5'd12, 5'd25, 6'd2, 0, 0);
        chk("ovf_sum", sum, 32'h00000001);

        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 4; j++) poke(5'($urandom), $urandom);
            rs = 5'($urandom);
            rd = 5'($urandom);
            do_cmd(rs, rd, 6'($urandom_range(0, 32)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_copy_engine.md
# dmem_copy_engine

Memory-side initiator for the single-port 32×32 data memory: copies a block of `len` words from `src` to `dst` through the memory's `we`/`a`/`wd`/`rd` port and accumulates a 32-bit sum of the words moved. It sits between control logic (start/busy/done handshake) and the data memory. The memory reads combinationally and writes on the rising clock edge, so the engine issues one read cycle and one write cycle per word.

## Interface
- `AW`, default 5: memory address width (depth 2^AW = 32 words)
- `DW`, default 32: data word width

- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  command strobe; sampled only in IDLE
- `src`  in  AW  first source word address
- `dst`  in  AW  first destination word address
- `len`  in  AW+1  word count, 0..32
- `busy`  out  1  high in RD and WR states
- `done`  out  1  one-cycle completion pulse
- `sum`  out  DW  modulo-2^DW sum of the words read; holds until the next accepted start
- `mem_we`  out  1  memory write enable
- `mem_a`  out  AW  memory word address
- `mem_wd`  out  DW  memory write data
- `mem_rd`  in  DW  memory read data, combinational from `mem_a`

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE:
  - `mem_we`=0, `mem_a`=0.
  - On `start`=1, latch `src`, `dst` and `len`; clear `cnt` and `sum`.
  - Next state is RD if `len`≠0, otherwise DONE.
- RD:
  - `mem_we`=0, `mem_a`=(src_r+cnt) mod 32.
  - At the edge: data_r←`mem_rd`, `sum`←`sum`+`mem_rd` (carry dropped). Next state is WR.
- WR:
  - `mem_we`=1, `mem_a`=(dst_r+cnt) mod 32, `mem_wd`=data_r.
  - At the edge: `cnt`←`cnt`+1. Next state is DONE if `cnt`+1==len_r, otherwise RD.
- DONE: `done`=1, `mem_we`=0. Next state is IDLE.
- `mem_wd` always equals data_r; its value only matters when `mem_we`=1.
- `cnt` is AW+1 bits wide. Address sums are AW bits and wrap modulo 32 (e.g. src=30, len=4 reads 30,31,0,1).
- `start` in any state other than IDLE is ignored; it is not queued. `start` is also ignored in DONE.
- Source and destination inputs may change freely after the start cycle, because only the latched copies are used.
- Overlap: words are copied in ascending order, and each read observes all earlier writes. If `dst` lies inside (src, src+len), the first (dst−src) words repeat as a pattern through the destination. This is the defined behaviour.

## Timing
- Reset values:
  - state=IDLE, `busy`=0, `done`=0, `sum`=0, data_r=0, `cnt`=0.
  - `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- `mem_we` is gated by `!reset`. A cycle with `reset`=1 never writes memory, even if the state is WR.
- Reset mid-operation: the engine enters IDLE at the next edge, and the remaining words are not copied. Words already written stay written. No `done` pulse is produced.
- Latency, with the start accepted at edge 0:
  - For `len`=L≥1: RD during cycle 1, WR during cycle 2, …, last WR during cycle 2L, `done` during cycle 2L+1, IDLE from cycle 2L+2.
  - `busy` is high for exactly 2L cycles.
  - For `len`=0: `done` during cycle 1, with no memory access and `busy` never high; `sum` is 0.
- A new `start` can be accepted in the first IDLE cycle after DONE. Back-to-back commands therefore have a minimum spacing of 2L+2 cycles.
- `sum` is final when `done` is high.

## Test plan
- Basic copy:
  - Stimulus: preload mem[2]=0x55, mem[3]=0, mem[4]=0x00020007; apply src=2, dst=20, len=3.
  - Required: mem[20..22]=0x55, 0, 0x00020007; `sum`=0x0002005C; `done` in cycle 7; `busy` high in cycles 1–6; exactly 3 cycles with `mem_we`=1.
- Zero length:
  - Stimulus: `len`=0, any `src`/`dst`.
  - Required: `done` in cycle 1; `mem_we` never high; `sum`=0; memory unchanged.
- Wrap and full length:
  - Stimulus: src=30, dst=10, len=4 with mem[30]=1, mem[31]=2, mem[0]=3, mem[1]=4. Then a second command with len=32, src=0, dst=0.
  - Required (first command): mem[10..13]=1,2,3,4; `sum`=10.
  - Required (second command): contents unchanged; `done` in cycle 65; `sum` equals the sum of all words.
- Overlap:
  - Stimulus: mem[0..3]=A,B,C,D; src=0, dst=1, len=3.
  - Required: mem[1..3]=A,A,A; `sum`=3A mod 2^32.
- Ignored start and reset:
  - Stimulus: pulse `start` again with a different `dst` during WR of a len=4 copy.
  - Required: the copy completes with the original `dst` and no second `done` occurs.
  - Stimulus: assert `reset` during the third WR cycle.
  - Required: `mem_we`=0 in that cycle; only 2 words written; `busy`=0 and `sum`=0 next cycle; no `done`.
- Sum overflow:
  - Stimulus: words 0xFFFFFFFF and 0x00000002, len=2.
  - Required: `sum`=0x00000001.
